// File: rtl/imem_loader_pkg.sv
// -----------------------------------------------------------------------------
// imem_loader_pkg
// Shared definitions for the instruction-memory program loader.
//   - state_e        : loader FSM states (CHK is only reachable when the
//                      IMEM_LOADER_CHECKSUM_EN macro is defined)
//   - DEPTH_DEF      : default instruction memory size in bytes
//   - ADDR_W_DEF     : default byte address width (clog2 of DEPTH_DEF)
//   - LEN_W_DEF      : default width of the stream length header
//   - is_loading()   : states in which the loader accepts stream bytes
// -----------------------------------------------------------------------------
package imem_loader_pkg;

    localparam int DEPTH_DEF  = 1024;
    localparam int ADDR_W_DEF = 10;
    localparam int LEN_W_DEF  = 16;

    typedef enum logic [2:0] {
        IDLE   = 3'd0,
        LEN_HI = 3'd1,
        LEN_LO = 3'd2,
        DATA   = 3'd3,
        CHK    = 3'd4,
        DONE   = 3'd5,
        ERR    = 3'd6
    } state_e;

    // States that take a byte from the stream; drives s_ready and busy.
    function automatic logic is_loading(input state_e st);
        logic res;
        case (st)
            LEN_HI, LEN_LO, DATA, CHK: res = 1'b1;
            default:                   res = 1'b0;
        endcase
        return res;
    endfunction

endpackage

// File: rtl/imem_loader.sv
// -----------------------------------------------------------------------------
// imem_loader
// Byte-stream program loader. Receives a length-framed byte stream
// (LEN_HI, LEN_LO, payload...) over valid/ready and writes each payload byte
// to the byte-addressed instruction memory, starting at address 0 in stream
// order. The datapath is held in reset (core_rst=1) until an image has been
// loaded completely.
//
// Optional build macro: IMEM_LOADER_CHECKSUM_EN
//   When defined, one extra byte follows the payload and must equal the XOR
//   of all payload bytes (8'h00 for an empty payload); otherwise the load
//   ends in ERR.
//
// Ports:
//   clk      in   clock, rising edge
//   rst      in   asynchronous active-low reset
//   start    in   one-cycle pulse that begins a load (ignored while busy)
//   s_valid  in   stream byte valid
//   s_data   in   stream byte
//   s_ready  out  loader accepts a byte this cycle (registered)
//   wr_en    out  instruction-memory byte write strobe
//   wr_addr  out  byte address of the write
//   wr_data  out  byte written
//   core_rst out  active-high datapath reset (low only in DONE)
//   busy     out  a load is in progress
//   done     out  last load completed successfully
//   err      out  last load failed
// -----------------------------------------------------------------------------
import imem_loader_pkg::*;

module imem_loader #(
    parameter int DEPTH  = DEPTH_DEF,
    parameter int ADDR_W = ADDR_W_DEF,
    parameter int LEN_W  = LEN_W_DEF
) (
    input  logic              clk,
    input  logic              rst,
    input  logic              start,
    input  logic              s_valid,
    input  logic [7:0]        s_data,
    output logic              s_ready,
    output logic              wr_en,
    output logic [ADDR_W-1:0] wr_addr,
    output logic [7:0]        wr_data,
    output logic              core_rst,
    output logic              busy,
    output logic              done,
    output logic              err
);

    state_e            state_q,    state_d;
    logic [LEN_W-1:0]  len_q,      len_d;
    logic [ADDR_W:0]   count_q,    count_d;
    logic              s_ready_q,  s_ready_d;
    logic              wr_en_q,    wr_en_d;
    logic [ADDR_W-1:0] wr_addr_q,  wr_addr_d;
    logic [7:0]        wr_data_q,  wr_data_d;
    logic              core_rst_q, core_rst_d;
    logic              busy_q,     busy_d;
    logic              done_q,     done_d;
    logic              err_q,      err_d;
`ifdef IMEM_LOADER_CHECKSUM_EN
    logic [7:0]        csum_q,     csum_d;
`endif

    logic              accept_s;
    logic [LEN_W-1:0]  len_new_s;
    logic [ADDR_W:0]   count_inc_s;
    state_e            end_state_s;

    assign accept_s    = s_valid & s_ready_q;
    // Length as it will be once the low header byte is captured.
    assign len_new_s   = {len_q[LEN_W-1:8], s_data};
    assign count_inc_s = count_q + {{ADDR_W{1'b0}}, 1'b1};
`ifdef IMEM_LOADER_CHECKSUM_EN
    assign end_state_s = CHK;
`else
    assign end_state_s = DONE;
`endif

    // Next-state, header/count bookkeeping and write-register computation.
    always_comb begin
        state_d   = state_q;
        len_d     = len_q;
        count_d   = count_q;
        wr_en_d   = 1'b0;
        wr_addr_d = wr_addr_q;
        wr_data_d = wr_data_q;
`ifdef IMEM_LOADER_CHECKSUM_EN
        csum_d    = csum_q;
`endif
        case (state_q)
            IDLE, DONE, ERR: begin
                if (start) begin
                    state_d = LEN_HI;
                    count_d = '0;
`ifdef IMEM_LOADER_CHECKSUM_EN
                    csum_d  = 8'h00;
`endif
                end else begin
                    state_d = state_q;
                end
            end
            LEN_HI: begin
                if (accept_s) begin
                    len_d   = {s_data, len_q[7:0]};
                    state_d = LEN_LO;
                end else begin
                    state_d = LEN_HI;
                end
            end
            LEN_LO: begin
                if (accept_s) begin
                    len_d   = len_new_s;
                    count_d = '0;
                    if (len_new_s == {LEN_W{1'b0}}) begin
                        state_d = end_state_s;
                    end else if (len_new_s > LEN_W'(DEPTH)) begin
                        state_d = ERR;
                    end else begin
                        state_d = DATA;
                    end
                end else begin
                    state_d = LEN_LO;
                end
            end
            DATA: begin
                if (accept_s) begin
                    wr_en_d   = 1'b1;
                    wr_addr_d = count_q[ADDR_W-1:0];
                    wr_data_d = s_data;
                    count_d   = count_inc_s;
`ifdef IMEM_LOADER_CHECKSUM_EN
                    csum_d    = csum_q ^ s_data;
`endif
                    // len <= DEPTH was enforced, so count never overflows.
                    if (LEN_W'(count_inc_s) == len_q) begin
                        state_d = end_state_s;
                    end else begin
                        state_d = DATA;
                    end
                end else begin
                    state_d = DATA;
                end
            end
`ifdef IMEM_LOADER_CHECKSUM_EN
            CHK: begin
                if (accept_s) begin
                    if (s_data == csum_q) begin
                        state_d = DONE;
                    end else begin
                        state_d = ERR;
                    end
                end else begin
                    state_d = CHK;
                end
            end
`endif
            default: begin
                state_d = IDLE;
            end
        endcase
    end

    // Status outputs are registered from the next state so they line up with it.
    always_comb begin
        s_ready_d  = is_loading(state_d);
        busy_d     = is_loading(state_d);
        done_d     = (state_d == DONE);
        err_d      = (state_d == ERR);
        core_rst_d = (state_d != DONE);
    end

    // State, counters and registered outputs.
    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            state_q    <= IDLE;
            len_q      <= '0;
            count_q    <= '0;
            s_ready_q  <= 1'b0;
            wr_en_q    <= 1'b0;
            wr_addr_q  <= '0;
            wr_data_q  <= 8'h00;
            core_rst_q <= 1'b1;
            busy_q     <= 1'b0;
            done_q     <= 1'b0;
            err_q      <= 1'b0;
`ifdef IMEM_LOADER_CHECKSUM_EN
            csum_q     <= 8'h00;
`endif
        end else begin
            state_q    <= state_d;
            len_q      <= len_d;
            count_q    <= count_d;
            s_ready_q  <= s_ready_d;
            wr_en_q    <= wr_en_d;
            wr_addr_q  <= wr_addr_d;
            wr_data_q  <= wr_data_d;
            core_rst_q <= core_rst_d;
            busy_q     <= busy_d;
            done_q     <= done_d;
            err_q      <= err_d;
`ifdef IMEM_LOADER_CHECKSUM_EN
            csum_q     <= csum_d;
`endif
        end
    end

    assign s_ready  = s_ready_q;
    assign wr_en    = wr_en_q;
    assign wr_addr  = wr_addr_q;
    assign wr_data  = wr_data_q;
    assign core_rst = core_rst_q;
    assign busy     = busy_q;
    assign done     = done_q;
    assign err      = err_q;

endmodule
